// File: rtl/packet_assembler.sv
// packet_assembler: collects WORD_WIDTH-bit words into PACKET_WORDS-word packets with padding, flush and idle timeout
//   clk, reset      : clock, synchronous active-high reset
//   in_data/valid   : input word stream; in_ready high when a word can be taken
//   flush           : close the current partial packet now
//   pkt_data/len    : registered packet (word 0 in the low bits) and its real word count
//   pkt_valid/ready : output slot handshake
module packet_assembler #(
    parameter int                    WORD_WIDTH     = 8,
    parameter int                    PACKET_WORDS   = 4,
    parameter logic [WORD_WIDTH-1:0] PAD_WORD       = '0,
    parameter int                    TIMEOUT_CYCLES = 0,
    localparam int                   LW             = $clog2(PACKET_WORDS + 1)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [WORD_WIDTH-1:0]              in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               flush,
    output logic [PACKET_WORDS*WORD_WIDTH-1:0] pkt_data,
    output logic [LW-1:0]                      pkt_len,
    output logic                               pkt_valid,
    input  logic                               pkt_ready
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 2);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                            state_q, state_d;
    logic [LW-1:0]                     cnt_q, cnt_d, cnt_new;
    logic [WORD_WIDTH-1:0]             buf_q [PACKET_WORDS];
    logic [WORD_WIDTH-1:0]             buf_d [PACKET_WORDS];
    logic [TW-1:0]                     tmo_q, tmo_d;
    logic [PACKET_WORDS*WORD_WIDTH-1:0] pkt_data_q, pkt_data_d, ld_data;
    logic [LW-1:0]                     pkt_len_q, pkt_len_d;
    logic                              pkt_valid_q, pkt_valid_d;
    logic                              acc, slot_free, tmo_hit, close, load;

    assign in_ready  = !reset && state_q == FILL;
    assign acc       = in_valid && in_ready;
    assign slot_free = !pkt_valid_q || pkt_ready;
    // count including a word accepted this cycle; in HOLD nothing is accepted so it equals cnt_q
    assign cnt_new   = cnt_q + LW'(acc);
    // tmo_q counts completed idle cycles, so the close fires on the TIMEOUT_CYCLES-th idle cycle
    assign tmo_hit   = TIMEOUT_CYCLES != 0 && state_q == FILL && cnt_q != 0 && !acc
                       && int'(tmo_q) + 1 == TIMEOUT_CYCLES;
    assign close     = state_q == FILL && cnt_new != 0
                       && (cnt_new == LW'(PACKET_WORDS) || flush || tmo_hit);
    assign load      = slot_free && (state_q == HOLD || close);

    always_comb begin
        buf_d   = buf_q;
        ld_data = '0;
        for (int k = 0; k < PACKET_WORDS; k++) begin
            if (acc && cnt_q == LW'(k)) buf_d[k] = in_data;
        end
        for (int k = 0; k < PACKET_WORDS; k++) begin
            ld_data[k*WORD_WIDTH +: WORD_WIDTH] = LW'(k) < cnt_new ? buf_d[k] : PAD_WORD;
        end
        pkt_data_d  = load ? ld_data : pkt_data_q;
        pkt_len_d   = load ? cnt_new : pkt_len_q;
        pkt_valid_d = load || (pkt_valid_q && !pkt_ready);
        cnt_d       = load ? '0 : cnt_new;
        state_d     = load ? FILL : close ? HOLD : state_q;
        tmo_d       = (TIMEOUT_CYCLES == 0 || state_q == HOLD || load || close || acc || cnt_new == 0)
                      ? '0 : tmo_q + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            buf_q       <= '{default: '0};
            tmo_q       <= '0;
            pkt_data_q  <= '0;
            pkt_len_q   <= '0;
            pkt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            tmo_q       <= tmo_d;
            pkt_data_q  <= pkt_data_d;
            pkt_len_q   <= pkt_len_d;
            pkt_valid_q <= pkt_valid_d;
        end
    end

    assign pkt_data  = pkt_data_q;
    assign pkt_len   = pkt_len_q;
    assign pkt_valid = pkt_valid_q;
endmodule

// File: tb/tb_packet_assembler.sv
// tb_packet_assembler: directed and randomized checks of packet_assembler against a queue-based model
module tb_packet_assembler;
    localparam int PW = 4;
    localparam int TMO = 5;
    localparam logic [7:0] PAD = 8'hFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [31:0] pkt_data;
    logic [2:0]  pkt_len;
    logic        pkt_valid;
    logic        pkt_ready = 1'b0;

    int total = 0;
    int bad = 0;

    // model: pending words, hold flag, idle counter, output slot
    logic [7:0]  mq[$];
    bit          m_hold = 0;
    bit          m_valid = 0;
    logic [31:0] m_data = '0;
    logic [2:0]  m_len = '0;
    int          m_idle = 0;

    packet_assembler #(.WORD_WIDTH(8), .PACKET_WORDS(PW), .PAD_WORD(PAD), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .pkt_data(pkt_data), .pkt_len(pkt_len), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready)
    );

    always #5 clk = ~clk;

    task automatic emit();
        m_data = {4{PAD}};
        foreach (mq[i]) m_data[i*8 +: 8] = mq[i];
        m_len = 3'(mq.size());
        m_valid = 1;
        mq.delete();
        m_idle = 0;
    endtask

    task automatic model(input bit v, input logic [7:0] d, input bit f, input bit r);
        bit free;
        bit close;
        if (reset) begin
            mq.delete();
            m_hold = 0; m_valid = 0; m_data = '0; m_len = '0; m_idle = 0;
            return;
        end
        free = !m_valid || r;
        if (m_valid && r) m_valid = 0;
        if (!m_hold) begin
            if (v) begin
                mq.push_back(d);
                m_idle = 0;
            end else if (mq.size() > 0) m_idle++;
            close = mq.size() == PW || (mq.size() > 0 && (f || (TMO > 0 && !v && m_idle == TMO)));
            if (close && free) emit();
            else if (close) m_hold = 1;
        end else if (free) begin
            emit();
            m_hold = 0;
        end
        if (mq.size() == 0) m_idle = 0;
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit f, input bit r);
        in_valid = v; in_data = d; flush = f; pkt_ready = r;
        @(posedge clk);
        model(v && !m_hold && !reset, d, f, r);
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        step(0, 0, 0, 0);
        step(1, 8'h12, 1, 1);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", pkt_valid); end
        total++; if (pkt_len !== 3'd0) begin bad++; $display("FAIL reset_len got=%0d exp=0", pkt_len); end
        total++; if (pkt_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", pkt_data); end
        reset = 0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL full_early_valid got=%b exp=0", pkt_valid); end
            step(1, 8'(8'h11 * (i + 1)), 0, 1);
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_in_ready got=%b exp=1", in_ready); end
        end
        total++; if (pkt_valid !== 1'b1) begin bad++; $display("FAIL full_valid got=%b exp=1", pkt_valid); end
        total++; if (pkt_data !== 32'h44332211) begin bad++; $display("FAIL full_data got=%h exp=44332211", pkt_data); end
        total++; if (pkt_len !== 3'd4) begin bad++; $display("FAIL full_len got=%0d exp=4", pkt_len); end
        step(0, 0, 0, 1);
        total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL full_consumed got=%b exp=0", pkt_valid); end
    endtask

    task automatic test_backpressure();
        for (int i = 1; i <= 8; i++) begin
            step(1, 8'(i), 0, 0);
            if (i == 4) begin
                total++; if (pkt_valid !== 1'b1) begin bad++; $display("FAIL bp_first_valid got=%b exp=1", pkt_valid); end
                total++; if (pkt_data !== 32'h04030201) begin bad++; $display("FAIL bp_first_data got=%h exp=04030201", pkt_data); end
            end
        end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_in_ready got=%b exp=0", in_ready); end
        step(1, 8'h99, 1, 0);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold2_in_ready got=%b exp=0", in_ready); end
        total++; if (pkt_data !== 32'h04030201) begin bad++; $display("FAIL bp_held_data got=%h exp=04030201", pkt_data); end
        step(0, 0, 0, 1);
        total++; if (pkt_valid !== 1'b1) begin bad++; $display("FAIL bp_second_valid got=%b exp=1", pkt_valid); end
        total++; if (pkt_data !== 32'h08070605) begin bad++; $display("FAIL bp_second_data got=%h exp=08070605", pkt_data); end
        total++; if (pkt_len !== 3'd4) begin bad++; $display("FAIL bp_second_len got=%0d exp=4", pkt_len); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
        step(0, 0, 0, 1);
        total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b exp=0", pkt_valid); end
    endtask

    task automatic test_flush();
        step(1, 8'hAA, 0, 1);
        step(1, 8'hBB, 0, 1);
        step(0, 0, 1, 1);
        total++; if (pkt_valid !== 1'b1) begin bad++; $display("FAIL flush_valid got=%b exp=1", pkt_valid); end
        total++; if (pkt_data !== {PAD, PAD, 8'hBB, 8'hAA}) begin bad++; $display("FAIL flush_data got=%h exp=%h", pkt_data, {PAD, PAD, 8'hBB, 8'hAA}); end
        total++; if (pkt_len !== 3'd2) begin bad++; $display("FAIL flush_len got=%0d exp=2", pkt_len); end
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL flush_empty got=%b exp=0", pkt_valid); end
    endtask

    task automatic test_timeout();
        step(1, 8'h5A, 0, 1);
        for (int i = 1; i < TMO; i++) begin
            step(0, 0, 0, 1);
            total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL tmo_early idle=%0d got=%b exp=0", i, pkt_valid); end
        end
        step(0, 0, 0, 1);
        total++; if (pkt_valid !== 1'b1) begin bad++; $display("FAIL tmo_valid got=%b exp=1", pkt_valid); end
        total++; if (pkt_data !== {PAD, PAD, PAD, 8'h5A}) begin bad++; $display("FAIL tmo_data got=%h exp=%h", pkt_data, {PAD, PAD, PAD, 8'h5A}); end
        total++; if (pkt_len !== 3'd1) begin bad++; $display("FAIL tmo_len got=%0d exp=1", pkt_len); end
        step(0, 0, 0, 1);
        for (int w = 0; w < 4; w++) begin
            step(1, 8'(8'hC0 + w), 0, 1);
            if (w < 3) for (int j = 0; j < 3; j++) begin
                step(0, 0, 0, 1);
                total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL tmo_spaced got=%b exp=0", pkt_valid); end
            end
        end
        total++; if (pkt_data !== 32'hC3C2C1C0) begin bad++; $display("FAIL tmo_spaced_data got=%h exp=C3C2C1C0", pkt_data); end
        step(0, 0, 0, 1);
    endtask

    task automatic test_simultaneous();
        for (int i = 1; i <= 3; i++) step(1, 8'(8'h70 + i), 0, 1);
        step(1, 8'h74, 1, 1);
        total++; if (pkt_len !== 3'd4) begin bad++; $display("FAIL simul_len got=%0d exp=4", pkt_len); end
        total++; if (pkt_data !== 32'h74737271) begin bad++; $display("FAIL simul_data got=%h exp=74737271", pkt_data); end
        step(0, 0, 0, 1);
        total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL simul_extra got=%b exp=0", pkt_valid); end
        step(1, 8'h81, 1, 1);
        total++; if (pkt_data !== {PAD, PAD, PAD, 8'h81}) begin bad++; $display("FAIL simul_single_data got=%h exp=%h", pkt_data, {PAD, PAD, PAD, 8'h81}); end
        total++; if (pkt_len !== 3'd1) begin bad++; $display("FAIL simul_single_len got=%0d exp=1", pkt_len); end
        step(0, 0, 0, 1);
    endtask

    task automatic test_reset_mid();
        step(1, 8'hE1, 0, 1);
        step(1, 8'hE2, 0, 1);
        reset = 1;
        step(0, 0, 0, 1);
        reset = 0;
        total++; if (pkt_data !== 32'h0) begin bad++; $display("FAIL rmid_data got=%h exp=0", pkt_data); end
        for (int i = 1; i <= 8; i++) step(1, 8'(8'h30 + i), 0, 0);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rmid_hold got=%b exp=0", in_ready); end
        reset = 1;
        step(0, 0, 0, 0);
        reset = 0;
        #1;
        total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", pkt_valid); end
        total++; if (pkt_len !== 3'd0) begin bad++; $display("FAIL rmid_len got=%0d exp=0", pkt_len); end
        total++; if (pkt_data !== 32'h0) begin bad++; $display("FAIL rmid_hold_data got=%h exp=0", pkt_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready); end
        for (int i = 1; i <= 4; i++) step(1, 8'(8'h40 + i), 0, 1);
        total++; if (pkt_data !== 32'h44434241) begin bad++; $display("FAIL rmid_clean_data got=%h exp=44434241", pkt_data); end
        total++; if (pkt_len !== 3'd4) begin bad++; $display("FAIL rmid_clean_len got=%0d exp=4", pkt_len); end
        step(0, 0, 0, 1);
    endtask

    task automatic test_random();
        int vp;
        for (int c = 0; c < 3000; c++) begin
            vp = ((c / 100) % 2) ? 85 : 15;
            step($urandom_range(0, 99) < vp, 8'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
            total++; if (in_ready !== !m_hold) begin bad++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", c, in_ready, !m_hold); end
            total++; if (pkt_valid !== m_valid) begin bad++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, pkt_valid, m_valid); end
            total++; if (pkt_data !== m_data) begin bad++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, pkt_data, m_data); end
            total++; if (pkt_len !== m_len) begin bad++; $display("FAIL rand_len cyc=%0d got=%0d exp=%0d", c, pkt_len, m_len); end
        end
    endtask

    initial begin
        test_reset();
        test_full();
        test_backpressure();
        test_flush();
        test_timeout();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
